// File: rtl/mc_control.sv
// Multicycle MIPS main control: Moore FSM stepping each instruction through
// fetch/decode/execute/memory/write-back and decoding every datapath control.
//
// state   | meaning
// FETCH   | read instruction, load IR, PC <= PC + 4
// DECODE  | read registers, precompute branch target, dispatch on opcode
// MEMADR  | effective address for lw/sw
// MEMRD   | data memory read (lw)
// MEMWB   | write MDR to rt (lw)
// MEMWR   | data memory write (sw)
// EXEC    | R-type ALU operation
// RTYPEWB | write ALUOut to rd
// BRANCH  | beq compare, conditional PC write
// JUMP    | PC <= jump target
// ADDIEX  | addi ALU operation
// ADDIWB  | write ALUOut to rt
module mc_control (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   output logic       pcWrite,
   output logic       pcWriteCond,
   output logic       iorD,
   output logic       memRead,
   output logic       memWrite,
   output logic       irWrite,
   output logic       memToReg,
   output logic       regDst,
   output logic       regWrite,
   output logic       aluSrcA,
   output logic [1:0] aluSrcB,
   output logic [1:0] opAlu,
   output logic [1:0] pcSource,
   output logic       badOp,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_EXEC    = 4'd6,
      S_RTYPEWB = 4'd7,
      S_BRANCH  = 4'd8,
      S_JUMP    = 4'd9,
      S_ADDIEX  = 4'd10,
      S_ADDIWB  = 4'd11
   } state_t;

   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_RTYP = 6'b000000;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;

   state_t     r_state;
   state_t     w_next;
   logic       w_pc_write, w_pc_write_cond, w_iord, w_mem_read, w_mem_write;
   logic       w_ir_write, w_mem_to_reg, w_reg_dst, w_reg_write, w_alu_src_a;
   logic       w_bad_op;
   logic [1:0] w_alu_src_b, w_op_alu, w_pc_source;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_FETCH;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next          = S_FETCH;
      w_pc_write      = 1'b0;
      w_pc_write_cond = 1'b0;
      w_iord          = 1'b0;
      w_mem_read      = 1'b0;
      w_mem_write     = 1'b0;
      w_ir_write      = 1'b0;
      w_mem_to_reg    = 1'b0;
      w_reg_dst       = 1'b0;
      w_reg_write     = 1'b0;
      w_alu_src_a     = 1'b0;
      w_alu_src_b     = 2'b00;
      w_op_alu        = 2'b00;
      w_pc_source     = 2'b00;
      w_bad_op        = 1'b0;
      case (r_state)
         S_FETCH: begin
            w_mem_read  = 1'b1;
            w_ir_write  = 1'b1;
            w_alu_src_b = 2'b01;
            w_pc_write  = 1'b1;
            w_next      = S_DECODE;
         end
         S_DECODE: begin
            w_alu_src_b = 2'b11;
            case (opcode)
               OP_LW, OP_SW: w_next = S_MEMADR;
               OP_RTYP:      w_next = S_EXEC;
               OP_BEQ:       w_next = S_BRANCH;
               OP_J:         w_next = S_JUMP;
               OP_ADDI:      w_next = S_ADDIEX;
               default: begin
                  w_bad_op = 1'b1;
                  w_next   = S_FETCH;
               end
            endcase
         end
         S_MEMADR, S_ADDIEX: begin
            w_alu_src_a = 1'b1;
            w_alu_src_b = 2'b10;
            if (r_state == S_ADDIEX) w_next = S_ADDIWB;
            else if (opcode == OP_SW) w_next = S_MEMWR;
            else w_next = S_MEMRD;
         end
         S_MEMRD: begin
            w_mem_read = 1'b1;
            w_iord     = 1'b1;
            w_next     = S_MEMWB;
         end
         S_MEMWB: begin
            w_reg_write  = 1'b1;
            w_mem_to_reg = 1'b1;
         end
         S_MEMWR: begin
            w_mem_write = 1'b1;
            w_iord      = 1'b1;
         end
         S_EXEC: begin
            w_alu_src_a = 1'b1;
            w_op_alu    = 2'b10;
            w_next      = S_RTYPEWB;
         end
         S_RTYPEWB: begin
            w_reg_write = 1'b1;
            w_reg_dst   = 1'b1;
         end
         S_BRANCH: begin
            w_alu_src_a     = 1'b1;
            w_op_alu        = 2'b01;
            w_pc_write_cond = 1'b1;
            w_pc_source     = 2'b01;
         end
         S_JUMP: begin
            w_pc_write  = 1'b1;
            w_pc_source = 2'b10;
         end
         S_ADDIWB: w_reg_write = 1'b1;
         default:  w_next = S_FETCH;
      endcase
   end

   // Gate with rst so nothing strobes while reset is held, even combinationally.
   assign pcWrite     = w_pc_write      & ~rst;
   assign pcWriteCond = w_pc_write_cond & ~rst;
   assign iorD        = w_iord          & ~rst;
   assign memRead     = w_mem_read      & ~rst;
   assign memWrite    = w_mem_write     & ~rst;
   assign irWrite     = w_ir_write      & ~rst;
   assign memToReg    = w_mem_to_reg    & ~rst;
   assign regDst      = w_reg_dst       & ~rst;
   assign regWrite    = w_reg_write     & ~rst;
   assign aluSrcA     = w_alu_src_a     & ~rst;
   assign aluSrcB     = w_alu_src_b     & {2{~rst}};
   assign opAlu       = w_op_alu        & {2{~rst}};
   assign pcSource    = w_pc_source     & {2{~rst}};
   assign badOp       = w_bad_op        & ~rst;
   assign state       = r_state;

endmodule
